// File: rtl/vsd_dac_pkg.sv
// Shared definitions for the DAC sample sequencer and core-side drivers.
package vsd_dac_pkg;

  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_CH_W   = 1;

  // Channel-select width; a single channel still carries one select bit.
  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Occupancy width able to represent a completely full FIFO.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [DEF_CH_W-1:0]   chan;
    logic [DEF_DATA_W-1:0] data;
  } sample_t;

endpackage

// File: rtl/vsd_dac_sequencer_if.sv
// Core-to-sequencer sample push port (valid/ready with channel and code).
interface vsd_dac_sequencer_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CH_W   = 1
);
  logic              s_valid;
  logic              s_ready;
  logic [CH_W-1:0]   s_chan;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_chan, output s_data, input s_ready);
  modport slave  (input s_valid, input s_chan, input s_data, output s_ready);
endinterface

// File: rtl/vsd_sample_fifo.sv
// Synchronous sample FIFO with async reset; no empty-bypass, push refused when full.
module vsd_sample_fifo #(
  parameter  int unsigned WIDTH = 11,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vsd_dac_sequencer.sv
// Multi-channel DAC sample sequencer: FIFO, programmable sample timer, channel registers, sticky flags.
// Optional slew limiting toward per-channel targets is compiled in with `define DAC_SLEW_EN.
module vsd_dac_sequencer
  import vsd_dac_pkg::*;
#(
  parameter  int unsigned DATA_W     = 10,
  parameter  int unsigned CHANNELS   = 2,
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned DIV_W      = 16,
  parameter  int unsigned STEP_MAX   = 4,
  localparam int unsigned CH_W       = ch_width(CHANNELS),
  localparam int unsigned LVL_W      = level_width(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div,
  vsd_dac_sequencer_if.slave         s,
  output logic [CHANNELS*DATA_W-1:0] dac_d,
  output logic [CHANNELS-1:0]        dac_update,
  output logic [LVL_W-1:0]           fifo_level,
  output logic                       underflow,
  output logic                       chan_err,
  input  logic                       clear_flags
);

  localparam int unsigned   ENT_W  = CH_W + DATA_W;
  localparam logic [CH_W:0] NUM_CH = (CH_W + 1)'(CHANNELS);

  logic [DIV_W-1:0]  cnt;
  logic              tick_c;
  logic              push_c;
  logic              pop_c;
  logic              load_c;
  logic              chan_ok_c;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic [CH_W-1:0]   head_chan;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] cur [CHANNELS];

  assign tick_c    = enable && (cnt >= div);
  assign push_c    = s.s_valid && !full;
  assign pop_c     = tick_c && !empty;
  assign s.s_ready = !full;
  assign {head_chan, head_data} = head;
  assign chan_ok_c = ({1'b0, head_chan} < NUM_CH);
  assign load_c    = pop_c && chan_ok_c;

  vsd_sample_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata ({s.s_chan, s.s_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Sample-period timer; >= compare makes a lowered div take effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Sticky flags; a set event in the same cycle overrides clear_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      chan_err  <= 1'b0;
    end else begin
      if (tick_c && empty)         underflow <= 1'b1;
      else if (clear_flags)        underflow <= 1'b0;
      if (pop_c && !chan_ok_c)     chan_err  <= 1'b1;
      else if (clear_flags)        chan_err  <= 1'b0;
    end
  end

`ifdef DAC_SLEW_EN
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STEP_MAX);

  logic [DATA_W-1:0] tgt   [CHANNELS];
  logic [DATA_W-1:0] nxt_c [CHANNELS];

  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] now,
                                             input logic [DATA_W-1:0] goal);
    logic [DATA_W-1:0] diff;
    if (goal > now) begin
      diff = goal - now;
      return now + ((diff > STEP) ? STEP : diff);
    end else begin
      diff = now - goal;
      return now - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) nxt_c[c] = slew(cur[c], tgt[c]);
  end

  // Ticks retarget a channel; the output walks toward the target every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_update <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cur[c] <= '0;
        tgt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cur[c]        <= nxt_c[c];
        dac_update[c] <= (nxt_c[c] != cur[c]);
        if (load_c && (head_chan == CH_W'(c))) tgt[c] <= head_data;
      end
    end
  end
`else
  // Ticks load the channel register directly and strobe its update line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_update <= '0;
      for (int c = 0; c < CHANNELS; c++) cur[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        dac_update[c] <= 1'b0;
        if (load_c && (head_chan == CH_W'(c))) begin
          cur[c]        <= head_data;
          dac_update[c] <= 1'b1;
        end
      end
    end
  end
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign dac_d[g*DATA_W +: DATA_W] = cur[g];
  end

endmodule

// File: tb/tb_vsd_dac_sequencer.sv
// Self-checking bench for vsd_dac_sequencer: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_vsd_dac_sequencer;
  import vsd_dac_pkg::*;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned STEP_MAX = 4;
  localparam int unsigned CH_W     = ch_width(CHANNELS);
  localparam int unsigned LVL_W    = level_width(DEPTH);

  typedef struct { int chan; int data; } word_t;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       enable = 1'b0;
  logic                       clear_flags = 1'b0;
  logic [DIV_W-1:0]           div = '0;
  logic [CHANNELS*DATA_W-1:0] dac_d;
  logic [CHANNELS-1:0]        dac_update;
  logic [LVL_W-1:0]           fifo_level;
  logic                       underflow;
  logic                       chan_err;

  vsd_dac_sequencer_if #(.DATA_W(DATA_W), .CH_W(CH_W)) sif ();

  vsd_dac_sequencer #(
    .DATA_W     (DATA_W),
    .CHANNELS   (CHANNELS),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W),
    .STEP_MAX   (STEP_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div         (div),
    .s           (sif),
    .dac_d       (dac_d),
    .dac_update  (dac_update),
    .fifo_level  (fifo_level),
    .underflow   (underflow),
    .chan_err    (chan_err),
    .clear_flags (clear_flags)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  // Reference state
  word_t mq[$];
  int    m_cnt = 0;
  int    m_dac [CHANNELS] = '{default: 0};
  int    m_tgt [CHANNELS] = '{default: 0};
  bit    m_upd [CHANNELS] = '{default: 1'b0};
  bit    m_uf = 1'b0;
  bit    m_ce = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one sample-clock step computed from the rules on queue occupancy and timer count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_cnt = 0;
      m_uf  = 1'b0;
      m_ce  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_dac[c] = 0;
        m_tgt[c] = 0;
        m_upd[c] = 1'b0;
      end
    end else begin
      bit    tick;
      bit    push;
      bit    uf_set;
      bit    ce_set;
      word_t w;
      tick   = enable && (m_cnt >= int'(div));
      push   = sif.s_valid && (mq.size() < DEPTH);
      uf_set = 1'b0;
      ce_set = 1'b0;
      for (int c = 0; c < CHANNELS; c++) m_upd[c] = 1'b0;
`ifdef DAC_SLEW_EN
      for (int c = 0; c < CHANNELS; c++) begin
        int d;
        d = m_tgt[c] - m_dac[c];
        if (d > 0)      m_dac[c] += (d > STEP_MAX) ? STEP_MAX : d;
        else if (d < 0) m_dac[c] -= (-d > STEP_MAX) ? STEP_MAX : -d;
        m_upd[c] = (d != 0);
      end
`endif
      if (tick) begin
        if (mq.size() == 0) uf_set = 1'b1;
        else begin
          w = mq.pop_front();
          if (w.chan < CHANNELS) begin
`ifdef DAC_SLEW_EN
            m_tgt[w.chan] = w.data;
`else
            m_dac[w.chan] = w.data;
            m_upd[w.chan] = 1'b1;
`endif
          end else ce_set = 1'b1;
        end
      end
      if (push) begin
        w.chan = int'(sif.s_chan);
        w.data = int'(sif.s_data);
        mq.push_back(w);
      end
      m_cnt = (tick || !enable) ? 0 : m_cnt + 1;
      if (uf_set) m_uf = 1'b1; else if (clear_flags) m_uf = 1'b0;
      if (ce_set) m_ce = 1'b1; else if (clear_flags) m_ce = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      logic [CHANNELS*DATA_W-1:0] ed;
      logic [CHANNELS-1:0]        eu;
      for (int c = 0; c < CHANNELS; c++) begin
        ed[c*DATA_W +: DATA_W] = DATA_W'(m_dac[c]);
        eu[c] = m_upd[c];
      end
      chk("dac_d", 64'(dac_d), 64'(ed));
      chk("dac_update", 64'(dac_update), 64'(eu));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("s_ready", 64'(sif.s_ready), 64'(mq.size() < DEPTH));
      chk("underflow", 64'(underflow), 64'(m_uf));
      chk("chan_err", 64'(chan_err), 64'(m_ce));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int chan, input int data);
    sif.s_valid = 1'b1;
    sif.s_chan  = CH_W'(chan);
    sif.s_data  = DATA_W'(data);
    step();
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_upd(input int ch, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = dac_update[ch];
    end
    chk("wait_update_timeout", 64'(seen), 64'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [CHANNELS*DATA_W-1:0] snap;
  int strobes;

  initial begin
    sif.s_valid = 1'b0;
    sif.s_chan  = '0;
    sif.s_data  = '0;
    step();
    step();
    armed = 1'b1;
    chk("reset_dac_d", 64'(dac_d), 64'd0);
    chk("reset_s_ready", 64'(sif.s_ready), 64'd1);
    chk("reset_level", 64'(fifo_level), 64'd0);
    reset = 1'b0;

    // Basic load to channel 0
    div    = DIV_W'(3);
    enable = 1'b1;
    push(0, 'h155);
    wait_upd(0, 20);
`ifndef DAC_SLEW_EN
    snap = dac_d;
    chk("basic_ch0", 64'(snap[0 +: DATA_W]), 64'h155);
    chk("basic_ch1", 64'(snap[DATA_W +: DATA_W]), 64'h0);
    step();
    chk("basic_strobe_one_cycle", 64'(dac_update), 64'h0);
`endif

    // Fill the FIFO with the timer stopped
    enable = 1'b0;
    step();
    sif.s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sif.s_chan = CH_W'(i % CHANNELS);
      sif.s_data = DATA_W'(16 * i + 3);
      step();
      if (i == 7) begin
        chk("full_ready_low", 64'(sif.s_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd8);
      end
    end
    sif.s_valid = 1'b0;
    chk("full_ninth_refused", 64'(fifo_level), 64'd8);
    enable  = 1'b1;
    strobes = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (dac_update != '0) strobes++;
    end
`ifndef DAC_SLEW_EN
    chk("full_drain_updates", 64'(strobes), 64'd8);
`endif
    chk("full_drained", 64'(fifo_level), 64'd0);

    // Underflow with empty FIFO
    enable      = 1'b0;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    snap   = dac_d;
    div    = DIV_W'(2);
    enable = 1'b1;
    repeat (4) step();
    chk("underflow_set", 64'(underflow), 64'd1);
    chk("underflow_dac_hold", 64'(dac_d), 64'(snap));
    enable      = 1'b0;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("underflow_cleared", 64'(underflow), 64'd0);

    // Out-of-range channel
    push(3, 'h3FF);
    div    = '0;
    enable = 1'b1;
    step();
    step();
    chk("bad_chan_err", 64'(chan_err), 64'd1);
    chk("bad_chan_consumed", 64'(fifo_level), 64'd0);
    enable = 1'b0;

    // Reset in the middle of activity
    for (int i = 0; i < 5; i++) push(i % CHANNELS, 40 + i);
    chk("midrun_level", 64'(fifo_level), 64'd5);
    reset = 1'b1;
    #1;
    chk("midrun_reset_level", 64'(fifo_level), 64'd0);
    chk("midrun_reset_dac", 64'(dac_d), 64'd0);
    chk("midrun_reset_flags", 64'({underflow, chan_err}), 64'd0);
    step();
    reset  = 1'b0;
    div    = DIV_W'(1);
    enable = 1'b1;
    repeat (6) step();
    chk("midrun_no_pops", 64'(dac_d), 64'd0);
    enable = 1'b0;

`ifdef DAC_SLEW_EN
    // Slew from 0 toward 10 in steps of STEP_MAX
    pulse_reset();
    push(1, 10);
    div    = '0;
    enable = 1'b1;
    wait_upd(1, 10);
    snap = dac_d;
    chk("slew_step1", 64'(snap[DATA_W +: DATA_W]), 64'd4);
    step();
    snap = dac_d;
    chk("slew_step2", 64'(snap[DATA_W +: DATA_W]), 64'd8);
    step();
    snap = dac_d;
    chk("slew_step3", 64'(snap[DATA_W +: DATA_W]), 64'd10);
    step();
    chk("slew_settled", 64'(dac_update), 64'd0);
    enable = 1'b0;
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      sif.s_valid = ($urandom_range(0, 2) != 0);
      sif.s_chan  = CH_W'($urandom_range(0, 3));
      sif.s_data  = DATA_W'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 4));
      clear_flags = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    sif.s_valid = 1'b0;
    reset       = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vsd_dac_sequencer.md
# vsd_dac_sequencer

Parametrised multi-channel sample sequencer between the RISC-V core and the DAC bank of the baby SoC, running on the PLL output clock. It generalises the single 10-bit core-to-DAC wire: the core pushes {channel, sample} words through a valid/ready port into a FIFO, and a programmable rate divider pops one word per sample period into per-channel DAC holding registers. Underflow and bad-channel events are flagged sticky, and optional slew limiting can be compiled in.

## Interface
- DATA_W, 10, DAC code width
- CHANNELS, 2, number of DAC channels (1..16); CH_W = max(1, $clog2(CHANNELS))
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- DIV_W, 16, sample-period divider width
- STEP_MAX, 4, max code change per cycle (only used with DAC_SLEW_EN)

Ports:
- clk  in  1  PLL clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run sample timer
- div  in  DIV_W  sample period minus one, in clk cycles
- s_valid  in  1  core sample valid
- s_ready  out  1  FIFO can accept
- s_chan  in  CH_W  target channel
- s_data  in  DATA_W  sample code
- dac_d  out  CHANNELS*DATA_W  packed channel codes; channel c at [c*DATA_W +: DATA_W]
- dac_update  out  CHANNELS  one-cycle strobe, high while that channel shows a new code
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- underflow  out  1  sticky: tick found FIFO empty
- chan_err  out  1  sticky: popped word had s_chan ≥ CHANNELS
- clear_flags  in  1  synchronous clear of both sticky flags

## Operation
- Push: s_valid && s_ready. s_ready = !full, combinational from FIFO state. No push when full, even when a pop occurs in the same cycle.
- Timer: cnt resets to 0. While enable is high, tick = (cnt >= div). On tick, cnt returns to 0; otherwise cnt increments. While enable is low, cnt is held at 0 and no ticks occur. The FIFO keeps accepting pushes.
- `>=` compare: lowering div mid-period ticks on the next cycle. div = 0 ticks every cycle.
- On tick with the FIFO non-empty: pop the head entry.
  - Valid channel: load the entry into channel register s_chan.
  - s_chan ≥ CHANNELS: discard the entry and set chan_err.
- On tick with the FIFO empty: set underflow; all channels hold their values.
- There is no empty-FIFO bypass. A push and a tick in the same cycle on an empty FIFO raise underflow, and the pushed word is stored.
- clear_flags clears both flags. If a set event occurs in the same cycle, set wins.
- Reset mid-operation: FIFO emptied, cnt = 0, flags = 0, all dac_d = 0, dac_update = 0.

## Timing
- Reset values:
  - dac_d = 0, dac_update = 0, fifo_level = 0, underflow = 0, chan_err = 0.
  - s_ready = 1 (empty FIFO).
- A push at edge t is reflected in fifo_level after edge t. It is eligible for pop from the tick evaluated in cycle t+1.
- A tick in cycle T pops at edge T. dac_d[c] and dac_update[c] are registered and valid after edge T. dac_update is high for exactly one cycle.
- Sample period with enable continuously high: div+1 cycles. The first tick comes div+1 cycles after enable rises.
- fifo_level is unchanged when a push and a pop occur in the same cycle.

## Configuration
- DAC_SLEW_EN defined:
  - A tick loads a per-channel target register instead of dac_d directly.
  - Every clk cycle, each dac_d channel moves toward its target by min(|target − dac_d|, STEP_MAX).
  - dac_update[c] is high on every cycle channel c changes.
  - Targets reset to 0.
- DAC_SLEW_EN undefined: no target registers. Behaviour is exactly as described in Operation. STEP_MAX is ignored.

## Structure
- Package vsd_dac_pkg: the CH_W/level-width helper functions and a packed struct sample_t {chan, data}. Shared with core-side drivers.
- One sub-module, vsd_sample_fifo: synchronous FIFO with async reset, push/pop/full/empty/level, no bypass.
- The timer, channel registers, optional slew logic and flags live in the top.

## Test plan
- Reset/basic: div=3, enable=1, push (ch0, 0x155) → dac_d[ch0]=0x155 with dac_update[0] one cycle, 4 cycles after the first eligible tick boundary; ch1 stays 0.
- Full FIFO: enable=0, push 9 words with DEPTH=8 → s_ready=0 after 8 pushes, 9th not accepted, fifo_level=8. Enable → 8 updates, in order, 4 cycles apart.
- Underflow: enable with empty FIFO, div=2 → underflow=1 after the first tick, dac_d unchanged. Then clear_flags → underflow=0.
- Bad channel: CHANNELS=3, push chan=3 data=0x3FF → chan_err=1, word consumed, no dac_update, fifo_level back to 0.
- Reset mid-run: assert reset with fifo_level=5 and nonzero outputs → all outputs at reset values immediately. After release, no pops until new pushes arrive.
- DAC_SLEW_EN, STEP_MAX=4: target 10 from 0 → dac_d steps 4, 8, 10 on consecutive cycles, with dac_update high for those 3 cycles.
